// File: rtl/aes_sbox_engine.sv
// Time-multiplexed AES SubBytes/InvSubBytes over a 128-bit state, LANES bytes per edge; out_valid after NCHUNK edges,
// or NCHUNK+1 with AES_SBOX_LOOKUP_REG_EN; data_out held until out_ready, and no new state is accepted until then.
module aes_sbox_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CWID   = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [127:0]    work;
    logic [127:0]    work_nxt;
    logic            mode_r;
    logic [CWID-1:0] chunk;
    logic [CWID-1:0] sub;
    logic [CWID-1:0] wr_dat;
    logic [CW-1:0]   wr_idx;
    logic            wr_en;
    logic            fin;

`ifdef AES_SBOX_LOOKUP_REG_EN
    // Lookup result for chunk k lands in work one edge later; look_done marks the last lookup issued.
    logic [CWID-1:0] pipe_dat;
    logic [CW-1:0]   pipe_idx;
    logic            pipe_vld;
    logic            look_done;

    assign wr_dat = pipe_dat;
    assign wr_idx = pipe_idx;
    assign wr_en  = pipe_vld;
    assign fin    = look_done;
`else
    assign wr_dat = sub;
    assign wr_idx = cnt;
    assign wr_en  = 1'b1;
    assign fin    = (cnt == LAST);
`endif

    always_comb begin
        chunk = work[127 - CWID*int'(cnt) -: CWID];
        sub   = '0;
        for (int i = 0; i < LANES; i++) begin
            sub[CWID-1-8*i -: 8] = mode_r ? SBOX_INV[chunk[CWID-1-8*i -: 8]]
                                          : SBOX_FWD[chunk[CWID-1-8*i -: 8]];
        end
        work_nxt = work;
        work_nxt[127 - CWID*int'(wr_idx) -: CWID] = wr_dat;
    end

    assign in_ready = (state == IDLE) && !rst;
    assign data_out = work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            mode_r    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_SBOX_LOOKUP_REG_EN
            pipe_dat  <= '0;
            pipe_idx  <= '0;
            pipe_vld  <= 1'b0;
            look_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state  <= BUSY;
                        work   <= data_in;
                        mode_r <= mode;
                        cnt    <= '0;
                        busy   <= 1'b1;
`ifdef AES_SBOX_LOOKUP_REG_EN
                        pipe_vld  <= 1'b0;
                        look_done <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    if (wr_en) work <= work_nxt;
                    // Counter saturates at the last chunk so it only ever restarts on entry to BUSY.
                    if (cnt != LAST) cnt <= cnt + 1'b1;
`ifdef AES_SBOX_LOOKUP_REG_EN
                    if (!look_done) begin
                        pipe_dat <= sub;
                        pipe_idx <= cnt;
                        pipe_vld <= 1'b1;
                        if (cnt == LAST) look_done <= 1'b1;
                    end
`endif
                    if (fin) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes_sbox_engine.md
Name: aes_sbox_engine

Overview:
- Multi-cycle byte-substitution engine for the AES128 datapaths. Applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to a full 128-bit state.
- Processes LANES bytes per clock behind valid/ready handshakes on both sides.
- Shared by the encryption and decryption round controllers in place of sixteen parallel LUT instances, trading area for latency.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- NCHUNK, 16/LANES (derived localparam), number of processing cycles per state.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled on input handshake
- in_valid  input  1  data_in/mode valid
- in_ready  output  1  engine can accept a state
- data_in  input  128  state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  data_out holds a completed result
- out_ready  input  1  downstream accepts data_out
- data_out  output  128  substituted state, same byte order as data_in
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, chunk counter=0, out_valid=0, data_out=0, busy=0, internal state/mode registers=0. in_ready=0 while rst is high, 1 on the first cycle after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, latch data_in into the work register and mode into the mode register, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each edge k (k=0..NCHUNK-1) replaces bytes k*LANES .. k*LANES+LANES-1 of the work register with S(b) or S^-1(b) according to the latched mode. Counter increments.
  - At k=NCHUNK-1, go to DONE.
  - Mode and data_in changes during BUSY are ignored.
- DONE:
  - out_valid=1; data_out = work register, held stable until handshake.
  - On out_valid&&out_ready, go to IDLE and drop out_valid. in_ready is high the following cycle.
- No same-cycle accept in DONE: one bubble cycle minimum between results.
- Latency: input handshake at edge T gives out_valid high after edge T+NCHUNK. For LANES=16, out_valid is high after edge T+1.
- Lookup: LANES instances each of forward and inverse S-box, fully combinational from the current chunk. Tables are the FIPS-197 S-box and its inverse.
- Counter width is max(1, $clog2(NCHUNK)). The counter wraps to 0 on entry to BUSY only, never mid-state.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-BUSY or mid-DONE aborts the operation: partial result discarded, data_out cleared, no out_valid pulse after release.
- in_valid held high with in_ready=0 is not an error; the request waits.

Optional Feature:
- Macro: AES_SBOX_LOOKUP_REG_EN.
- Defined:
  - A register stage sits between the lookup LUTs and the work-register write; the pipeline is drained in an extra BUSY cycle.
  - Latency is NCHUNK+1; out_valid is high after edge T+NCHUNK+1.
  - The pipeline register resets to 0 and is flushed on reset.
  - Throughput is otherwise unchanged.
- Undefined: purely combinational lookup, latency NCHUNK.

Test Plan:
- LANES=4, mode=0, data_in=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_valid high after 4 edges (5 with AES_SBOX_LOOKUP_REG_EN); data_out=d42711aee0bf98f1b8b45de51e415230; in_ready low during BUSY/DONE.
- Same bench, mode=1, data_in=d42711aee0bf98f1b8b45de51e415230 -> data_out=193de3bea0f4e22b9ac68d2ae9f84808.
- mode=1, data_in all 0x63 -> all 0x00. mode=1, data_in all 0x00 -> all 0x52. mode=0, data_in all 0x53 -> all 0xed.
- Backpressure: out_ready=0 for 10 cycles after out_valid; toggle data_in and mode during that time -> data_out stable, in_ready=0, result released on out_ready=1; in_ready=1 next cycle.
- Assert rst for one cycle at the second BUSY edge -> out_valid, data_out, busy immediately 0. No out_valid for 20 cycles without a new request; a new request then completes correctly.
- Sweep LANES=1,2,8,16 with random states, forward then inverse -> round trip equals input. Latency equals 16, 8, 2, 1 cycles respectively (+1 with AES_SBOX_LOOKUP_REG_EN).
